bcd_disp2: RTL

Two-digit multiplexed 7-segment display driver for the BCD up/down counter outputs (`bcd1` tens, `bcd0` units). It runs a time-sliced scan that alternates between the two common-anode digits and samples both digits once per frame so the display never tears. It includes a dead time between digits to suppress ghosting and shows a dash for non-BCD codes. It sits between the counter and the board's seven-segment pins.

---
 rtl/bcd_disp2.sv | 88 ++++++++
 1 files changed

// File: rtl/bcd_disp2.sv
// Two-digit multiplexed common-anode 7-segment driver with per-frame shadow sampling.
// Optional leading-zero blanking of the tens digit: define BCD_DISP2_LZB_EN.
module bcd_disp2 #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  output logic [6:0] seg,
  output logic [1:0] com
);

  localparam int            CW     = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
  localparam logic [6:0]    BLANK  = 7'h7F;

  typedef enum logic {PH_UNITS = 1'b0, PH_TENS = 1'b1} phase_t;

  logic [CW-1:0] cnt;
  phase_t        p;
  logic [3:0]    sh0, sh1;
  logic [3:0]    digit;
  logic [6:0]    seg_d;
  logic [1:0]    com_d;

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 7'h40;
      4'd1:    font = 7'h79;
      4'd2:    font = 7'h24;
      4'd3:    font = 7'h30;
      4'd4:    font = 7'h19;
      4'd5:    font = 7'h12;
      4'd6:    font = 7'h02;
      4'd7:    font = 7'h78;
      4'd8:    font = 7'h00;
      4'd9:    font = 7'h10;
      default: font = 7'h3F;
    endcase
  endfunction

  // Outputs are decoded from the current position so seg and com switch together.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    com_d = 2'b11;
    seg_d = BLANK;
    digit = (p == PH_TENS) ? sh1 : sh0;
    if (en && (cnt >= DEAD_C)) begin
      com_d = (p == PH_TENS) ? 2'b01 : 2'b10;
      seg_d = font(digit);
`ifdef BCD_DISP2_LZB_EN
      if ((p == PH_TENS) && (sh1 == 4'd0)) seg_d = BLANK;
`endif
    end
  end

  // NOTE: all state uses non-blocking assignments; clr resets asynchronously and
  // immediately, independent of the scan position.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
      p   <= PH_UNITS;
      sh0 <= 4'd0;
      sh1 <= 4'd0;
      seg <= BLANK;
      com <= 2'b11;
    end else begin
      if (cnt == LAST) begin
        cnt <= '0;
        p   <= (p == PH_TENS) ? PH_UNITS : PH_TENS;
        // End of frame: both digits are captured on the same edge, so no tearing.
        if (p == PH_TENS) begin
          sh0 <= bcd0;
          sh1 <= bcd1;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
      seg <= seg_d;
      com <= com_d;
    end
  end

endmodule
